// File: rtl/burst_mem_responder_pkg.sv
// Types shared by the burst memory responder and cacheline_adaptor:
// beat geometry and the responder state encoding.
package mem_burst_types;
  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = BEATS * BEAT_W;
  localparam int OFFSET_BITS = 5;
  localparam int BEAT_BITS   = 2;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RD  = 3'd1,
    WAIT_WR  = 3'd2,
    BURST_RD = 3'd3,
    BURST_WR = 3'd4,
    DONE     = 3'd5
  } resp_state_e;
endpackage

// File: rtl/burst_mem_responder_if.sv
// 64-bit, 4-beat burst bus between the cacheline adaptor (master) and memory (slave).
interface burst_mem_responder_if;
  import mem_burst_types::*;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  beat_t       mem_wdata;
  logic        mem_resp;
  beat_t       mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/burst_mem_responder_array.sv
// Beat-addressed line store: one synchronous write port, one combinational read port
// so read data lines up with mem_resp in the same cycle.
module burst_mem_array
  import mem_burst_types::*;
#(
  parameter int INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [BEAT_BITS-1:0]  wr_beat,
  input  beat_t                 wr_data,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [BEAT_BITS-1:0]  rd_beat,
  output beat_t                 rd_data
);
  beat_t mem [2**(INDEX_BITS+BEAT_BITS)];

  always_ff @(posedge clk) begin
    if (we) mem[{wr_index, wr_beat}] <= wr_data;
  end

  assign rd_data = mem[{rd_index, rd_beat}];
endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat burst bus: serves one cacheline per transaction
// after a programmable latency and flags protocol violations in a sticky bit.
//
// state    | meaning
// IDLE     | waiting for a single request; both high flags an error
// WAIT_RD  | read accepted, counting READ_LATENCY
// WAIT_WR  | write accepted, counting WRITE_LATENCY
// BURST_RD | 4 beats of read data with mem_resp
// BURST_WR | 4 write-beat acks, each capturing mem_wdata
// DONE     | one quiet cycle, requests ignored
module burst_mem_responder
  import mem_burst_types::*;
#(
  parameter int INDEX_BITS    = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  burst_mem_responder_if.slave   bus,
  output logic                   busy,
  output logic                   proto_err
);
  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_WAIT_RD  = WAIT_RD;
  localparam logic [2:0] ST_WAIT_WR  = WAIT_WR;
  localparam logic [2:0] ST_BURST_RD = BURST_RD;
  localparam logic [2:0] ST_BURST_WR = BURST_WR;
  localparam logic [2:0] ST_DONE     = DONE;
  localparam int         CNT_W       = 8;

  logic [2:0]            state;
  logic [BEAT_BITS-1:0]  beat;
  logic [CNT_W-1:0]      lat_cnt;
  logic [INDEX_BITS-1:0] index;
  beat_t                 rd_data;
  logic                  rd_active;
  logic                  wr_active;
  logic                  active_req;
  logic                  opp_req;
  logic                  we;
  logic                  unused_addr_bits;

  assign rd_active  = (state == ST_WAIT_RD) || (state == ST_BURST_RD);
  assign wr_active  = (state == ST_WAIT_WR) || (state == ST_BURST_WR);
  assign active_req = rd_active ? bus.mem_read  : bus.mem_write;
  assign opp_req    = rd_active ? bus.mem_write : bus.mem_read;

  assign bus.mem_resp  = (state == ST_BURST_RD) || (state == ST_BURST_WR);
  assign bus.mem_rdata = (state == ST_BURST_RD) ? rd_data : '0;
  assign busy          = (state != ST_IDLE);

  // A reset landing on a write beat must not commit that beat.
  assign we = (state == ST_BURST_WR) && !rst;

  assign unused_addr_bits = ^{bus.mem_addr[31:INDEX_BITS+OFFSET_BITS],
                              bus.mem_addr[OFFSET_BITS-1:0]};

  burst_mem_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk      (clk),
    .we       (we),
    .wr_index (index),
    .wr_beat  (beat),
    .wr_data  (bus.mem_wdata),
    .rd_index (index),
    .rd_beat  (beat),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat      <= '0;
      lat_cnt   <= '0;
      index     <= '0;
      proto_err <= 1'b0;
    end else begin
      // Active request must stay high through the last beat; the opposite one must stay low.
      if ((rd_active || wr_active) && (!active_req || opp_req)) proto_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (bus.mem_read && bus.mem_write) begin
            proto_err <= 1'b1;
          end else if (bus.mem_read) begin
            index <= bus.mem_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
            if (READ_LATENCY == 0) begin
              state <= ST_BURST_RD;
            end else begin
              state   <= ST_WAIT_RD;
              lat_cnt <= CNT_W'(READ_LATENCY - 1);
            end
          end else if (bus.mem_write) begin
            index <= bus.mem_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
            if (WRITE_LATENCY == 0) begin
              state <= ST_BURST_WR;
            end else begin
              state   <= ST_WAIT_WR;
              lat_cnt <= CNT_W'(WRITE_LATENCY - 1);
            end
          end
        end
        ST_WAIT_RD: begin
          if (lat_cnt == '0) state <= ST_BURST_RD;
          else lat_cnt <= lat_cnt - 1'b1;
        end
        ST_WAIT_WR: begin
          if (lat_cnt == '0) state <= ST_BURST_WR;
          else lat_cnt <= lat_cnt - 1'b1;
        end
        ST_BURST_RD, ST_BURST_WR: begin
          beat <= beat + 1'b1;
          if (beat == BEAT_BITS'(BEATS - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: default-latency instance plus a zero-latency one.
module tb_burst_mem_responder;
  import mem_burst_types::*;

  logic clk = 1'b0;
  logic rst;
  logic busy, proto_err, busy0, perr0;
  int   tests = 0;
  int   fails = 0;

  logic [255:0] l1, l2, l5, l_mix;
  logic [20:0]  seen;
  logic [6:0]   seen0;

  burst_mem_responder_if bus ();
  burst_mem_responder_if bus0 ();

  burst_mem_responder #(.INDEX_BITS(10), .READ_LATENCY(4), .WRITE_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .proto_err(proto_err)
  );

  burst_mem_responder #(.INDEX_BITS(10), .READ_LATENCY(0), .WRITE_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .proto_err(perr0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // rst_at >= 0 asserts rst in the cycle of that write beat instead of acking it.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int rst_at);
    int b = 0;
    int n = 0;
    bit finished = 1'b0;
    bit aborted = 1'b0;
    bus.mem_write = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = line[63:0];
    while (!finished && n < 40) begin
      @(negedge clk); n++;
      if (bus.mem_resp) begin
        if (b == 0) check("wr_first_lat", 64'(n), 64'd3);
        if (b == rst_at) rst = 1'b1;
        @(posedge clk); #1;
        if (rst) begin
          rst = 1'b0;
          bus.mem_write = 1'b0;
          aborted = 1'b1;
          finished = 1'b1;
        end else begin
          b++;
          if (b < 4) bus.mem_wdata = line[b*64 +: 64];
          else begin
            bus.mem_write = 1'b0;
            finished = 1'b1;
          end
        end
      end
    end
    check("wr_finished", 64'(finished), 64'd1);
    if (!aborted) begin
      @(negedge clk);
      check("wr_done_resp", 64'(bus.mem_resp), 64'd0);
      @(negedge clk);
      check("wr_idle_busy", 64'(busy), 64'd0);
    end
  endtask

  // drop_at: beat count after which mem_read is released early; opp pulses mem_write mid-wait.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input int drop_at, input bit opp);
    int b = 0;
    int k = 0;
    bus.mem_read = 1'b1;
    bus.mem_addr = addr;
    while (b < 4 && k < 40) begin
      @(negedge clk); k++;
      if (k == 1) check("rd_rdata_idle", bus.mem_rdata, 64'd0);
      if (opp && k == 2) bus.mem_write = 1'b1;
      if (opp && k == 3) bus.mem_write = 1'b0;
      if (bus.mem_resp) begin
        if (b == 0) check("rd_first_lat", 64'(k), 64'd5);
        check($sformatf("rd_beat%0d", b), bus.mem_rdata, line[b*64 +: 64]);
        @(posedge clk); #1;
        b++;
        if (b == 4 || b == drop_at) bus.mem_read = 1'b0;
      end
    end
    check("rd_beats", 64'(b), 64'd4);
    @(negedge clk);
    check("rd_done_resp", 64'(bus.mem_resp), 64'd0);
    check("rd_done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("rd_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.mem_addr = '0;  bus.mem_wdata = '0;
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0;
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    l5 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
          64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    l_mix = {l2[255:128], l5[127:0]};
    @(negedge clk);
    do_reset();
    check("rst_resp",  64'(bus.mem_resp), 64'd0);
    check("rst_rdata", bus.mem_rdata, 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_perr",  64'(proto_err), 64'd0);

    // Basic write then read of the same line
    do_write(32'h0000_0040, l1, -1);
    do_read(32'h0000_0040, l1, -1, 1'b0);
    check("t1_perr", 64'(proto_err), 64'd0);

    // Upper address bits alias, low 5 bits ignored
    do_write(32'h0000_8040, l2, -1);
    do_read(32'h0000_005F, l2, -1, 1'b0);
    check("t2_perr", 64'(proto_err), 64'd0);

    // Simultaneous read and write in IDLE
    bus.mem_read = 1'b1; bus.mem_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_resp", 64'(bus.mem_resp), 64'd0);
      check("t3_busy", 64'(busy), 64'd0);
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t3_perr_sticky", 64'(proto_err), 64'd1);
    do_reset();
    check("t3_perr_clr", 64'(proto_err), 64'd0);

    // Read held across DONE starts a second burst
    seen = '0;
    bus.mem_read = 1'b1; bus.mem_addr = 32'h0000_0040;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      seen[k] = bus.mem_resp;
      if (k == 9)  check("t4_done_busy", 64'(busy), 64'd1);
      if (k == 10) check("t4_gap_busy", 64'(busy), 64'd0);
      if (k == 15) check("t4_2nd_beat0", bus.mem_rdata, l2[63:0]);
      if (k == 18) begin @(posedge clk); #1; bus.mem_read = 1'b0; end
    end
    check("t4_resp_pattern", 64'(seen), 64'h781E0);
    check("t4_perr", 64'(proto_err), 64'd0);

    // Zero-latency instance: first ack one cycle after acceptance
    seen0 = '0;
    bus0.mem_write = 1'b1; bus0.mem_addr = 32'h0000_0020; bus0.mem_wdata = 64'h0123_4567_89AB_CDEF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      seen0[k] = bus0.mem_resp;
      if (k == 4) begin @(posedge clk); #1; bus0.mem_write = 1'b0; end
    end
    check("t4_zl_wr_pattern", 64'(seen0), 64'h1E);
    seen0 = '0;
    bus0.mem_read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      seen0[k] = bus0.mem_resp;
      if (k == 1) check("t4_zl_rd_beat0", bus0.mem_rdata, 64'h0123_4567_89AB_CDEF);
      if (k == 4) begin @(posedge clk); #1; bus0.mem_read = 1'b0; end
    end
    check("t4_zl_rd_pattern", 64'(seen0), 64'h1E);
    check("t4_zl_perr", 64'(perr0), 64'd0);

    // Reset during write beat 2: beats 0-1 new, 2-3 old
    do_write(32'h0000_0040, l5, 2);
    @(negedge clk);
    check("t5_resp_after_rst", 64'(bus.mem_resp), 64'd0);
    check("t5_busy_after_rst", 64'(busy), 64'd0);
    do_read(32'h0000_0040, l_mix, -1, 1'b0);

    // Read dropped after beat 1 still delivers all beats and flags an error
    do_read(32'h0000_0040, l_mix, 2, 1'b0);
    check("t6_perr", 64'(proto_err), 64'd1);

    // Opposite request during a read is ignored but flagged
    do_reset();
    do_read(32'h0000_0040, l_mix, -1, 1'b1);
    check("t7_perr", 64'(proto_err), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
